// File: rtl/wash_controller_if.sv
// Button/sensor inputs and display outputs of the wash controller.
// The controller is the master; the display/debounce side is the slave.
interface wash_controller_if;
  logic       pwr_btn;
  logic       start_btn;
  logic       mode_btn;
  logic       lid_open;
  logic [2:0] state;
  logic [9:0] data;
  logic [5:0] inLeft;
  logic [5:0] inMiddle;
  logic [5:0] inRight;

  modport master (
    input  pwr_btn, start_btn, mode_btn, lid_open,
    output state, data, inLeft, inMiddle, inRight
  );

  modport slave (
    output pwr_btn, start_btn, mode_btn, lid_open,
    input  state, data, inLeft, inMiddle, inRight
  );
endinterface

// File: rtl/wash_controller.sv
// Washing-machine control FSM: sequences wash/rinse/dry phases and drives the display.
// Define WASH_AUTO_OFF_EN to enable the idle auto-off timeout in set/pause.
module wash_controller #(
  parameter int TICK_DIV     = 50000000,
  parameter int PHASE_TICKS  = 3,
  parameter int BEGIN_TICKS  = 2,
  parameter int FINISH_TICKS = 3,
  parameter int IDLE_TICKS   = 10
) (
  input  logic              cp,
  input  logic              reset,
  wash_controller_if.master bus
);
  localparam int              TDW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TDW-1:0]  TICK_LAST   = TDW'(TICK_DIV - 1);
  localparam logic [3:0]      PHASE_LAST  = 4'(PHASE_TICKS - 1);
  localparam logic [7:0]      BEGIN_LAST  = 8'(BEGIN_TICKS - 1);
  localparam logic [7:0]      FINISH_LAST = 8'(FINISH_TICKS - 1);
  localparam logic [6:0]      PT7         = 7'(PHASE_TICKS);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_BEGIN  = 3'd1,
    S_SET    = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4,
    S_PAUSE  = 3'd5,
    S_FINISH = 3'd6
  } state_e;

  function automatic logic [7:0] prog_mask(input logic [2:0] m);
    case (m)
      3'd1:    prog_mask = 8'hFF;
      3'd2:    prog_mask = 8'hC0;
      3'd3:    prog_mask = 8'hFC;
      3'd4:    prog_mask = 8'h3F;
      3'd5:    prog_mask = 8'h3C;
      3'd6:    prog_mask = 8'h03;
      default: prog_mask = 8'h00;
    endcase
  endfunction

  // Positions count from the MSB (position p is data bit 7-p); 8 means none found.
  function automatic logic [3:0] find_from(input logic [7:0] mask, input logic [3:0] start);
    logic [3:0] pos;
    logic       found;
    logic [2:0] idx;
    pos   = 4'd8;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(7 - i);
      if (!found && i >= 32'(start) && mask[idx]) begin
        pos   = 4'(i);
        found = 1'b1;
      end
    end
    return pos;
  endfunction

  function automatic logic [3:0] count_from(input logic [7:0] mask, input logic [2:0] start);
    logic [3:0] n;
    logic [2:0] idx;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(7 - i);
      if (i >= 32'(start) && mask[idx]) n = n + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [7:0] live_bits(input logic [7:0] mask, input logic [2:0] ptr,
                                           input logic blink);
    logic [7:0] b;
    logic [2:0] idx;
    logic [2:0] p;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(i);
      p   = 3'(7 - i);
      if (p < ptr)       b[idx] = 1'b0;
      else if (p == ptr) b[idx] = blink;
      else               b[idx] = mask[idx];
    end
    return b;
  endfunction

  state_e         state_q, state_d;
  logic [2:0]     mode_q, mode_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [3:0]     pcnt_q, pcnt_d;
  logic           blink_q, blink_d;
  logic [7:0]     stage_q, stage_d;
  logic [TDW-1:0] tick_q, tick_d;
  logic [9:0]     data_q, data_d;
  logic [5:0]     left_q, left_d;
  logic [5:0]     right_q, right_d;
  logic           tick;
  logic [7:0]     mask_cur, mask_d;
  logic [3:0]     nxt;
  logic [6:0]     rem;
`ifdef WASH_AUTO_OFF_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);
  logic [7:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ptr_d    = ptr_q;
    pcnt_d   = pcnt_q;
    blink_d  = blink_q;
    stage_d  = stage_q;
    tick     = (tick_q == TICK_LAST);
    mask_cur = prog_mask(mode_q);
    nxt      = find_from(mask_cur, {1'b0, ptr_q} + 4'd1);

    if (state_q != S_OFF && bus.pwr_btn) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:   if (bus.pwr_btn) state_d = S_BEGIN;
        S_BEGIN: if (tick) begin
          if (stage_q == BEGIN_LAST) state_d = S_SET;
          else                       stage_d = stage_q + 8'd1;
        end
        S_SET: begin
          if (bus.start_btn) begin
            state_d = S_RUN;
            ptr_d   = 3'(find_from(mask_cur, 4'd0));
            pcnt_d  = '0;
            blink_d = 1'b1;
          end else if (bus.mode_btn) begin
            mode_d = (mode_q == 3'd6) ? 3'd1 : mode_q + 3'd1;
          end
        end
        S_RUN: begin
          if (bus.lid_open)       state_d = S_ERROR;
          else if (bus.start_btn) state_d = S_PAUSE;
          else if (tick) begin
            if (pcnt_q == PHASE_LAST) begin
              pcnt_d = '0;
              if (nxt[3]) begin
                state_d = S_FINISH;
              end else begin
                ptr_d   = nxt[2:0];
                blink_d = 1'b1;
              end
            end else begin
              pcnt_d  = pcnt_q + 4'd1;
              blink_d = ~blink_q;
            end
          end
        end
        S_PAUSE: if (bus.start_btn) state_d = S_RUN;
        S_ERROR: if (bus.start_btn && !bus.lid_open) state_d = S_RUN;
        S_FINISH: if (tick) begin
          if (stage_q == FINISH_LAST) state_d = S_OFF;
          else                        stage_d = stage_q + 8'd1;
        end
        default: state_d = S_OFF;
      endcase
    end

`ifdef WASH_AUTO_OFF_EN
    idle_d = idle_q;
    if ((state_q == S_SET || state_q == S_PAUSE) && state_d == state_q) begin
      if (bus.mode_btn || bus.start_btn) idle_d = '0;
      else if (tick) begin
        if (idle_q == IDLE_LAST) state_d = S_OFF;
        else                     idle_d  = idle_q + 8'd1;
      end
    end
`endif

    // Every state change restarts the tick divider and per-state timers.
    if (state_d != state_q) begin
      tick_d  = '0;
      stage_d = '0;
`ifdef WASH_AUTO_OFF_EN
      idle_d  = '0;
`endif
    end else begin
      tick_d = tick ? '0 : tick_q + 1'b1;
    end
  end

  // Outputs are derived from next-state values so they land together with state.
  always_comb begin
    mask_d = prog_mask(mode_d);
    data_d = '0;
    rem    = '0;
    case (state_d)
      S_BEGIN, S_FINISH: data_d = 10'h100;
      S_SET: begin
        data_d = {2'b11, mask_d};
        rem    = 7'(count_from(mask_d, 3'd0)) * PT7;
      end
      S_RUN, S_PAUSE, S_ERROR: begin
        data_d = {2'b01, live_bits(mask_d, ptr_d, blink_d)};
        rem    = 7'(count_from(mask_d, ptr_d)) * PT7 - 7'(pcnt_d);
      end
      default: data_d = '0;
    endcase
    if (rem > 7'd99) rem = 7'd99;
    left_d  = 6'(rem / 7'd10);
    right_d = 6'(rem % 7'd10);
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      state_q <= S_OFF;
      mode_q  <= 3'd1;
      ptr_q   <= '0;
      pcnt_q  <= '0;
      blink_q <= 1'b0;
      stage_q <= '0;
      tick_q  <= '0;
      data_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      pcnt_q  <= pcnt_d;
      blink_q <= blink_d;
      stage_q <= stage_d;
      tick_q  <= tick_d;
      data_q  <= data_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

`ifdef WASH_AUTO_OFF_EN
  always_ff @(posedge cp) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  assign bus.state    = state_q;
  assign bus.data     = data_q;
  assign bus.inLeft   = left_q;
  assign bus.inMiddle = {3'b000, mode_q};
  assign bus.inRight  = right_q;
endmodule

// File: tb/tb_wash_controller.sv
// Directed self-checking bench for wash_controller with a 4-cycle tick.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_wash_controller;
  logic cp;
  logic reset;
  int   checks;
  int   fails;

  wash_controller_if bus();

  wash_controller #(
    .TICK_DIV    (4),
    .PHASE_TICKS (3),
    .BEGIN_TICKS (2),
    .FINISH_TICKS(3),
    .IDLE_TICKS  (10)
  ) dut (
    .cp   (cp),
    .reset(reset),
    .bus  (bus)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cp);
      #1;
    end
  endtask

  task automatic press(input logic p, input logic s, input logic m);
    bus.pwr_btn   = p;
    bus.start_btn = s;
    bus.mode_btn  = m;
    step(1);
    bus.pwr_btn   = 1'b0;
    bus.start_btn = 1'b0;
    bus.mode_btn  = 1'b0;
  endtask

  task automatic power_on;
    press(1'b1, 1'b0, 1'b0);
    step(8);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    checks++; if (bus.state !== 3'd0) begin fails++; $display("FAIL reset state: got %0d want 0", bus.state); end
    checks++; if (bus.data !== 10'h000) begin fails++; $display("FAIL reset data: got %0h want 0", bus.data); end
    checks++; if (bus.inMiddle !== 6'd1) begin fails++; $display("FAIL reset inMiddle: got %0d want 1", bus.inMiddle); end
    checks++; if (bus.inLeft !== 6'd0 || bus.inRight !== 6'd0) begin fails++; $display("FAIL reset digits: got %0d%0d want 00", bus.inLeft, bus.inRight); end
  endtask

  task automatic test_power_on;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL begin state: got %0d want 1", bus.state); end
    checks++; if (bus.data !== 10'h100) begin fails++; $display("FAIL begin data: got %0h want 100", bus.data); end
    step(7);
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL begin hold: got %0d want 1", bus.state); end
    step(1);
    checks++; if (bus.state !== 3'd2) begin fails++; $display("FAIL set entry: got %0d want 2", bus.state); end
    checks++; if (bus.data !== 10'h3FF) begin fails++; $display("FAIL set data: got %0h want 3ff", bus.data); end
    checks++; if (bus.inMiddle !== 6'd1 || bus.inLeft !== 6'd2 || bus.inRight !== 6'd4) begin
      fails++; $display("FAIL set digits: got m%0d %0d%0d want m1 24", bus.inMiddle, bus.inLeft, bus.inRight); end
  endtask

  task automatic test_mode_select;
    logic [5:0] exp_mid   [6] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd1};
    logic [9:0] exp_data  [6] = '{10'h3C0, 10'h3FC, 10'h33F, 10'h33C, 10'h303, 10'h3FF};
    logic [5:0] exp_left  [6] = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd0, 6'd2};
    logic [5:0] exp_right [6] = '{6'd6, 6'd8, 6'd8, 6'd2, 6'd6, 6'd4};
    for (int k = 0; k < 6; k++) begin
      press(1'b0, 1'b0, 1'b1);
      checks++; if (bus.inMiddle !== exp_mid[k]) begin fails++; $display("FAIL mode %0d inMiddle: got %0d want %0d", k, bus.inMiddle, exp_mid[k]); end
      checks++; if (bus.data !== exp_data[k]) begin fails++; $display("FAIL mode %0d data: got %0h want %0h", k, bus.data, exp_data[k]); end
      checks++; if (bus.inLeft !== exp_left[k] || bus.inRight !== exp_right[k]) begin
        fails++; $display("FAIL mode %0d digits: got %0d%0d want %0d%0d", k, bus.inLeft, bus.inRight, exp_left[k], exp_right[k]); end
    end
  endtask

  task automatic test_run_program2;
    logic [9:0] exp_data  [5] = '{10'h140, 10'h1C0, 10'h140, 10'h100, 10'h140};
    logic [5:0] exp_right [5] = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    press(1'b0, 1'b0, 1'b1);
    checks++; if (bus.inMiddle !== 6'd2) begin fails++; $display("FAIL prog2 select: got %0d want 2", bus.inMiddle); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd3 || bus.data !== 10'h1C0 || bus.inRight !== 6'd6) begin
      fails++; $display("FAIL run start: got s%0d d%0h r%0d want s3 d1c0 r6", bus.state, bus.data, bus.inRight); end
    for (int k = 0; k < 5; k++) begin
      step(4);
      checks++; if (bus.data !== exp_data[k] || bus.inRight !== exp_right[k] || bus.inLeft !== 6'd0) begin
        fails++; $display("FAIL run tick %0d: got d%0h %0d%0d want d%0h 0%0d", k + 1, bus.data, bus.inLeft, bus.inRight, exp_data[k], exp_right[k]); end
    end
    step(4);
    checks++; if (bus.state !== 3'd6 || bus.data !== 10'h100 || bus.inRight !== 6'd0) begin
      fails++; $display("FAIL finish entry: got s%0d d%0h r%0d want s6 d100 r0", bus.state, bus.data, bus.inRight); end
    step(11);
    checks++; if (bus.state !== 3'd6) begin fails++; $display("FAIL finish hold: got %0d want 6", bus.state); end
    step(1);
    checks++; if (bus.state !== 3'd0 || bus.data !== 10'h000) begin
      fails++; $display("FAIL finish to off: got s%0d d%0h want s0 d0", bus.state, bus.data); end
  endtask

  task automatic test_lid_error;
    power_on();
    for (int k = 0; k < 5; k++) press(1'b0, 1'b0, 1'b1);
    checks++; if (bus.inMiddle !== 6'd1) begin fails++; $display("FAIL lid mode: got %0d want 1", bus.inMiddle); end
    press(1'b0, 1'b1, 1'b0);
    step(5);
    checks++; if (bus.inLeft !== 6'd2 || bus.inRight !== 6'd3) begin fails++; $display("FAIL lid pre: got %0d%0d want 23", bus.inLeft, bus.inRight); end
    bus.lid_open = 1'b1;
    step(1);
    checks++; if (bus.state !== 3'd4 || bus.data !== 10'h17F) begin fails++; $display("FAIL lid error: got s%0d d%0h want s4 d17f", bus.state, bus.data); end
    step(10);
    checks++; if (bus.state !== 3'd4 || bus.inLeft !== 6'd2 || bus.inRight !== 6'd3) begin
      fails++; $display("FAIL error freeze: got s%0d %0d%0d want s4 23", bus.state, bus.inLeft, bus.inRight); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd4) begin fails++; $display("FAIL start lid open: got %0d want 4", bus.state); end
    bus.lid_open = 1'b0;
    step(1);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd3 || bus.data !== 10'h17F || bus.inLeft !== 6'd2 || bus.inRight !== 6'd3) begin
      fails++; $display("FAIL error resume: got s%0d d%0h %0d%0d want s3 d17f 23", bus.state, bus.data, bus.inLeft, bus.inRight); end
    step(4);
    checks++; if (bus.data !== 10'h1FF || bus.inRight !== 6'd2) begin fails++; $display("FAIL resume tick: got d%0h r%0d want d1ff r2", bus.data, bus.inRight); end
  endtask

  task automatic test_pause;
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd5) begin fails++; $display("FAIL pause entry: got %0d want 5", bus.state); end
    bus.lid_open = 1'b1;
    step(12);
    bus.lid_open = 1'b0;
    checks++; if (bus.state !== 3'd5 || bus.data !== 10'h1FF || bus.inLeft !== 6'd2 || bus.inRight !== 6'd2) begin
      fails++; $display("FAIL pause freeze: got s%0d d%0h %0d%0d want s5 d1ff 22", bus.state, bus.data, bus.inLeft, bus.inRight); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd3) begin fails++; $display("FAIL pause resume: got %0d want 3", bus.state); end
    step(4);
    checks++; if (bus.data !== 10'h17F || bus.inLeft !== 6'd2 || bus.inRight !== 6'd1) begin
      fails++; $display("FAIL pause phase adv: got d%0h %0d%0d want d17f 21", bus.data, bus.inLeft, bus.inRight); end
  endtask

  task automatic test_priority;
    press(1'b1, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd0 || bus.data !== 10'h000) begin fails++; $display("FAIL pwr+start: got s%0d d%0h want s0 d0", bus.state, bus.data); end
    power_on();
    press(1'b0, 1'b1, 1'b0);
    checks++; if (bus.state !== 3'd3) begin fails++; $display("FAIL prio run: got %0d want 3", bus.state); end
    bus.lid_open = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    bus.lid_open = 1'b0;
    checks++; if (bus.state !== 3'd4) begin fails++; $display("FAIL lid+start: got %0d want 4", bus.state); end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (bus.state !== 3'd0) begin fails++; $display("FAIL pwr in error: got %0d want 0", bus.state); end
  endtask

  task automatic test_reset_midrun;
    power_on();
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    checks++; if (bus.inMiddle !== 6'd3) begin fails++; $display("FAIL midrun mode: got %0d want 3", bus.inMiddle); end
    press(1'b0, 1'b1, 1'b0);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.data !== 10'h000) begin fails++; $display("FAIL midrun reset: got s%0d d%0h want s0 d0", bus.state, bus.data); end
    checks++; if (bus.inMiddle !== 6'd1 || bus.inLeft !== 6'd0 || bus.inRight !== 6'd0) begin
      fails++; $display("FAIL midrun digits: got m%0d %0d%0d want m1 00", bus.inMiddle, bus.inLeft, bus.inRight); end
  endtask

  task automatic test_idle;
    power_on();
    step(39);
    checks++; if (bus.state !== 3'd2) begin fails++; $display("FAIL idle hold: got %0d want 2", bus.state); end
    step(1);
`ifdef WASH_AUTO_OFF_EN
    checks++; if (bus.state !== 3'd0) begin fails++; $display("FAIL auto off: got %0d want 0", bus.state); end
`else
    step(20);
    checks++; if (bus.state !== 3'd2) begin fails++; $display("FAIL no auto off: got %0d want 2", bus.state); end
`endif
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.pwr_btn   = 1'b0;
    bus.start_btn = 1'b0;
    bus.mode_btn  = 1'b0;
    bus.lid_open  = 1'b0;
    test_reset();
    test_power_on();
    test_mode_select();
    test_run_program2();
    test_lid_error();
    test_pause();
    test_priority();
    test_reset_midrun();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wash_controller.md
Name: wash_controller

Overview:
- Control FSM for the washing machine; the producer side of the display/LED interface.
- Consumes single-cycle button pulses from the debouncer and a lid sensor.
- Sequences the wash/rinse/dry phases of the selected program.
- Drives the display block's `state`, `data`, `inLeft`, `inMiddle` and `inRight` inputs.

Parameters:
- TICK_DIV, 50000000: cp cycles per one-second tick.
- PHASE_TICKS, 3: ticks per phase, range 1..12.
- BEGIN_TICKS, 2: lamp-test duration in the begin state.
- FINISH_TICKS, 3: hold time in the finish state before shutting down.
- IDLE_TICKS, 10: idle timeout in the set state (used only with the optional feature).

Ports:
- cp, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- pwr_btn, input, 1: power toggle pulse, one cycle wide.
- start_btn, input, 1: start/pause/resume pulse.
- mode_btn, input, 1: program-select pulse.
- lid_open, input, 1: door-open sensor level.
- state, output, 3: 0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish.
- data, output, 10: [9] set, [8] power, [7] w_inWater, [6] w_W, [5] r_outWater, [4] r_spin, [3] r_inWater, [2] r_R, [1] d_outWater, [0] d_spin.
- inLeft, output, 6: tens digit of remaining program seconds (code 0..9).
- inMiddle, output, 6: program number (code 1..6).
- inRight, output, 6: units digit of remaining program seconds.

Behaviour:
- Reset:
  - state=0, data=0, inLeft=inRight=0, inMiddle=1.
  - mode=1; tick divider cleared; phase pointer cleared.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick pulses for one cycle at the wrap.
  - Cleared on every state change so that each state's timing starts from a full tick.
- Global rules:
  - pwr_btn in any state except shutDown -> shutDown next cycle. pwr_btn has priority over all other inputs.
  - All outputs are registered: one cycle of latency from the causing input or tick.
- Phase list, 8 bits in data[7:0] order:
  - wash = bits 7, 6.
  - rinse = bits 5, 4, 3, 2.
  - dry = bits 1, 0.
- Programs:
  - 1: wash + rinse + dry.
  - 2: wash.
  - 3: wash + rinse.
  - 4: rinse + dry.
  - 5: rinse.
  - 6: dry.
  - Phases run MSB to LSB, skipping phases not in the program.
- FSM:
  - shutDown: pwr_btn -> begin.
  - begin: after BEGIN_TICKS ticks -> set.
  - set: mode_btn -> mode+1, wrapping 6 -> 1. start_btn -> run at the first phase of the program with the phase counter at 0.
  - run: start_btn -> pause. lid_open (level, sampled every cycle) -> error. lid_open takes priority over a simultaneous start_btn. On each tick the phase counter increments; at PHASE_TICKS it resets and the pointer advances. After the last phase -> finish.
  - pause: start_btn -> run. Timing resumes at the same phase with the same counter. lid_open is ignored.
  - error: start_btn while lid_open=0 -> run, resuming as from pause. start_btn while lid_open=1 is ignored.
  - finish: after FINISH_TICKS ticks -> shutDown.
- data[9:8]:
  - data[9]=1 only in set.
  - data[8]=1 in every state except shutDown.
- data[7:0]:
  - set: the program's phase mask, all phases of the selected program shown as 1.
  - run/pause/error: completed phases 0; pending phases 1.
  - Current phase in run: toggles on each tick.
  - Current phase in pause and error: frozen at its last value.
  - shutDown, begin and finish: data[7:0]=0. The display block overrides these states anyway.
- Remaining time:
  - remaining = (phases left, including current) * PHASE_TICKS - phase counter.
  - Saturates at 99 for display.
  - inLeft = remaining/10, inRight = remaining%10, computed combinationally from registers and then registered.
  - In set, shows the full program time.
  - Width rules: the 8*12=96 maximum fits 7 bits.

Optional Feature:
- Macro: WASH_AUTO_OFF_EN.
- Defined:
  - An idle counter counts ticks in set and clears on any mode_btn or start_btn.
  - Reaching IDLE_TICKS -> shutDown.
  - Also applies in pause, with the counter cleared on entry.
- Undefined: set and pause wait indefinitely, and no idle counter is synthesized.

Test Plan (TICK_DIV=4, PHASE_TICKS=3):
- Reset, then pwr_btn: state 0 -> 1. After 2 ticks (8 cycles) -> 2 with data=0x3FF (set, power, program-1 mask 0xFF), inMiddle=1, inLeft=2, inRight=4.
- In set, mode_btn x6: inMiddle steps 2, 3, 4, 5, 6, 1. At mode 6: data[7:0]=0x03 and remaining=6.
- Mode 2, start_btn: run with data[7] blinking on each tick. After 3 ticks data[7]=0 and data[6] is active. After 6 ticks -> finish; after 3 more ticks -> shutDown with data=0.
- During run, assert lid_open: state=4 next cycle and the digits freeze. start_btn with lid still open is ignored. Release lid, then start_btn: state=3 with the same remaining time.
- start_btn in the same cycle as pwr_btn during run -> shutDown. start_btn in the same cycle as lid_open -> error.
- Reset asserted mid-run -> next cycle state=0, data=0, inMiddle=1. With WASH_AUTO_OFF_EN defined, 10 idle ticks in set -> shutDown.
